// File: rtl/wb_cmd_master_if.sv
// Host command/response port and Wishbone classic master bus for wb_cmd_master.
// The master modport is the bus master's view; slave is the host/slave side.
`timescale 1ns/1ps

interface wb_cmd_master_if #(
    parameter int ADR_W = 8,
    parameter int DAT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [DAT_W-1:0] cmd_dat;
    logic             rsp_valid;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             CYC_O;
    logic             STB_O;
    logic             WE_O;
    logic [ADR_W-1:0] ADR_O;
    logic [DAT_W-1:0] DAT_O;
    logic [DAT_W-1:0] DAT_I;
    logic             ACK_I;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               CYC_O, STB_O, WE_O, ADR_O, DAT_O
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               CYC_O, STB_O, WE_O, ADR_O, DAT_O
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready host port.
// Optional WB_TIMEOUT_EN macro adds a wait counter that aborts a cycle after TIMEOUT cycles.
`timescale 1ns/1ps

module wb_cmd_master #(
    parameter int ADR_W   = 8,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    wb_cmd_master_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT must be in 1..65535");
    end

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_TIMEOUT_EN
    logic [15:0] wait_q, wait_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout_hit;

    // Counter value k means k ACK-less BUS cycles already elapsed; this cycle is number k+1.
    assign timeout_hit = (({1'b0, wait_q} + 17'd1) == 17'(TIMEOUT));
    assign wait_d      = (state_q == BUS && !bus.ACK_I) ? wait_q + 16'd1 : 16'd0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus.ACK_I) begin
                    rsp_dat_d = we_q ? '0 : bus.DAT_I;
`ifdef WB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = DONE;
                end
`ifdef WB_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wait_q    <= 16'd0;
            rsp_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Bus strobes decode straight from the state register so reset drops them asynchronously.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.CYC_O     = (state_q == BUS);
    assign bus.STB_O     = (state_q == BUS);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.WE_O      = we_q;
    assign bus.ADR_O     = adr_q;
    assign bus.DAT_O     = dat_q;
    assign bus.rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized scoreboard bench for wb_cmd_master: memory-backed slave, transaction-level model.
`timescale 1ns/1ps

module tb_wb_cmd_master;

    localparam int ADR_W   = 8;
    localparam int DAT_W   = 32;
    localparam int TIMEOUT = 10;
`ifdef WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAX_WAIT = TO_EN ? 13 : 6;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] cdat;
        logic [31:0] rdat;
        logic        err;
        int          stb_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus_if ();

    wb_cmd_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus_if)
    );

    exp_t        exp_q[$];
    int          wait_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];
    int          checks = 0;
    int          fails  = 0;
    bit          stray_force = 1'b0;
    int          txn_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Transaction-level reference: outcome depends only on command, memory and slave latency.
    task automatic model(input logic we, input logic [7:0] adr, input logic [31:0] dat, input int w);
        exp_t e;
        e.we   = we;
        e.adr  = adr;
        e.cdat = dat;
        if (TO_EN && w >= TIMEOUT) begin
            e.rdat    = 32'h0;
            e.err     = 1'b1;
            e.stb_len = TIMEOUT;
        end else begin
            e.err     = 1'b0;
            e.stb_len = w + 1;
            if (we) begin
                e.rdat       = 32'h0;
                ref_mem[adr] = dat;
            end else begin
                e.rdat = ref_mem[adr];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                         input int w, input int gap);
        bit ok = 1'b0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_we    = we;
        bus_if.cmd_adr   = adr;
        bus_if.cmd_dat   = dat;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL handshake_timeout: actual=cmd_ready low for 200 cycles required=cmd_ready high");
        end else begin
            model(we, adr, dat, w);
            wait_q.push_back(w);
            txn_no++;
            $display("txn %0d: we=%0d adr=0x%02h dat=0x%08h wait=%0d", txn_no, we, adr, dat, w);
        end
        @(negedge clk);
        if (gap > 0) begin
            bus_if.cmd_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        bus_if.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Memory-backed slave: ACKs after the latency chosen for the current command.
    initial begin : slave
        bit active = 1'b0;
        int cnt = 0;
        int w = 0;
        bus_if.ACK_I = 1'b0;
        bus_if.DAT_I = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                bus_if.ACK_I = 1'b0;
            end else if (bus_if.STB_O === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (wait_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL bus_unexpected: actual=STB_O high required=no command pending");
                        w = 0;
                    end else begin
                        w = wait_q.pop_front();
                    end
                end
                if (cnt == w) begin
                    bus_if.ACK_I = 1'b1;
                    if (bus_if.WE_O) begin
                        slv_mem[bus_if.ADR_O] = bus_if.DAT_O;
                        bus_if.DAT_I = $urandom;
                    end else begin
                        bus_if.DAT_I = slv_mem[bus_if.ADR_O];
                    end
                end else begin
                    bus_if.ACK_I = 1'b0;
                    bus_if.DAT_I = $urandom;
                end
                cnt++;
            end else begin
                active = 1'b0;
                bus_if.ACK_I = stray_force || ($urandom_range(0, 3) == 0);
                bus_if.DAT_I = $urandom;
            end
        end
    end

    // Monitor: checks bus stability per strobe cycle and pops the scoreboard on each response.
    initial begin : monitor
        int stb_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stb_cnt = 0;
            end else begin
                if (bus_if.STB_O === 1'b1) begin
                    stb_cnt++;
                    chk("cyc_with_stb", 32'(bus_if.CYC_O), 32'd1);
                    chk("ready_during_bus", 32'(bus_if.cmd_ready), 32'd0);
                    if (exp_q.size() != 0) begin
                        chk("bus_we", 32'(bus_if.WE_O), 32'(exp_q[0].we));
                        chk("bus_adr", 32'(bus_if.ADR_O), 32'(exp_q[0].adr));
                        chk("bus_dat", bus_if.DAT_O, exp_q[0].cdat);
                    end
                end
                if (bus_if.rsp_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL rsp_unexpected: actual=rsp_valid high dat=0x%08h required=no response", bus_if.rsp_dat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_dat", bus_if.rsp_dat, e.rdat);
                        chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
                        chk("stb_len", 32'(stb_cnt), 32'(e.stb_len));
                        chk("cyc_low_in_done", 32'(bus_if.CYC_O), 32'd0);
                        $display("rsp: dat=0x%08h err=%0d stb_cycles=%0d", bus_if.rsp_dat, bus_if.rsp_err, stb_cnt);
                    end
                    stb_cnt = 0;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] v;
        bit ok;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        slv_mem[4] = 32'hDEAD_BEEF;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = 8'h0;
        bus_if.cmd_dat   = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        chk("rst_cyc", 32'(bus_if.CYC_O), 32'd0);
        chk("rst_stb", 32'(bus_if.STB_O), 32'd0);
        chk("rst_we", 32'(bus_if.WE_O), 32'd0);
        chk("rst_adr", 32'(bus_if.ADR_O), 32'd0);
        chk("rst_dat", bus_if.DAT_O, 32'd0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_dat", bus_if.rsp_dat, 32'd0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 8'h12, 32'hA5A5_0001, 0, 2);
        issue(1'b0, 8'h04, 32'h1234_5678, 3, 2);
        issue(1'b1, 8'h40, 32'h0000_0040, 0, 0);
        issue(1'b0, 8'h40, 32'hFFFF_FFFF, 0, 0);
        issue(1'b0, 8'h12, 32'h0, 1, 2);
        if (TO_EN) begin
            issue(1'b0, 8'h20, 32'h0, TIMEOUT - 1, 1);
            issue(1'b0, 8'h21, 32'h0, TIMEOUT, 1);
            issue(1'b1, 8'h22, 32'hCAFE_F00D, TIMEOUT + 2, 1);
            issue(1'b0, 8'h22, 32'h0, 0, 1);
        end
        drain();

        stray_force = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stray_ack_rsp", 32'(bus_if.rsp_valid), 32'd0);
            chk("stray_ack_ready", 32'(bus_if.cmd_ready), 32'd1);
        end
        stray_force = 1'b0;

        for (int n = 0; n < 120; n++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, MAX_WAIT), $urandom_range(0, 2));
        end
        drain();

        issue(1'b0, 8'h30, 32'h0, 40, 1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.STB_O === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_stb_seen", 32'(ok), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_cyc_async", 32'(bus_if.CYC_O), 32'd0);
        chk("abort_stb_async", 32'(bus_if.STB_O), 32'd0);
        exp_q.delete();
        wait_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
            chk("abort_ready", 32'(bus_if.cmd_ready), 32'd1);
        end

        for (int n = 0; n < 20; n++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, MAX_WAIT), $urandom_range(0, 2));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
